mul_rs_ctrl: RTL and testbench
==============================

Name: mul_rs_ctrl

Overview:
- Reservation-station and issue controller for the pipelined multiply functional unit; it drives the unit's EN, A and B inputs and collects its res/finish outputs.
- Holds up to two pending multiply ops. Waits for their source operands on the common data bus (CDB) broadcast, starts the oldest ready op, and arbitrates the product back onto the CDB.
- Sits between the issue stage and the multiply unit inside the Tomasulo core.

Parameters:
- TAG_W, 3, width of RS/producer tags; tag 0 means "value present, no producer".
- FU_LAT, 7, cycles from the EN sample to the finish pulse; also used as the post-reset drain length.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  new multiply op offered
- issue_ready  out  1  a free entry exists and the controller is not draining
- issue_dest  in  TAG_W  tag this op writes on the CDB (never 0)
- issue_qj, issue_qk  in  TAG_W  producer tags of operands A and B
- issue_vj, issue_vk  in  32  operand values; used when the matching q is 0
- bcast_valid  in  1  CDB broadcast this cycle
- bcast_tag  in  TAG_W  broadcast tag
- bcast_data  in  32  broadcast value
- fu_en  out  1  one-cycle start pulse to the multiply unit
- fu_a, fu_b  out  32  operands, held stable from the fu_en cycle until finish
- fu_res  in  32  product low word, valid while fu_finish is high
- fu_finish  in  1  one-cycle completion pulse
- cdb_req  out  1  request to write the CDB
- cdb_tag  out  TAG_W  dest tag of the held result
- cdb_data  out  32  held product
- cdb_grant  in  1  CDB arbiter grant; the write completes in this cycle

Behaviour:
- Reset, synchronous:
  - Both entries invalid; age bit cleared; FSM goes to DRAIN with counter = FU_LAT.
  - fu_en = 0, fu_a = fu_b = 0, cdb_req = 0, cdb_tag = 0, cdb_data = 0, issue_ready = 0.
- Entries: each holds valid, dest, qj, vj, qk, vk. An age bit marks the older entry.
- issue_ready = not DRAIN and at least one entry is invalid.
- Issue handshake (issue_valid && issue_ready): writes the lowest-index free entry; the new entry becomes the younger one.
- Wakeup, every cycle, for each valid entry:
  - If bcast_valid and qj == bcast_tag with qj != 0, then vj <= bcast_data and qj <= 0.
  - The same rule applies independently to qk.
  - On the issue cycle, each issue_q is compared with the same-cycle broadcast and, on a match, captured as ready. No wakeup is lost.
- Ready entry: valid with qj == 0 and qk == 0. If both are ready, the older one is selected.
- FSM:
  - DRAIN: counter decrements each cycle; at 0 go to IDLE. This guarantees a multiply still in flight across reset has finished.
  - IDLE: if a ready entry exists, go to START; record the entry index; load fu_a/fu_b from it.
  - START: fu_en = 1 for exactly this one cycle; go to BUSY.
  - BUSY: wait for fu_finish. On finish, capture fu_res into cdb_data and the entry's dest into cdb_tag, free the entry, assert cdb_req, go to WB.
  - WB: hold cdb_req/cdb_tag/cdb_data stable until cdb_grant. On grant, deassert cdb_req the next cycle and go to IDLE. No new fu_en while in WB.
- Minimum latency: operands ready in the IDLE cycle give fu_en 1 cycle later and cdb_req FU_LAT+1 cycles after fu_en.
- The freed entry may accept an issue in the same cycle it is freed, taking effect next cycle.
- fu_finish outside BUSY is ignored.
- Broadcasts of our own result, fed back externally, wake dependent entries normally.
- fu_a/fu_b hold their last values outside START/BUSY.
- Multiply is unsigned; the product is truncated to 32 bits.
- Reset in any state aborts everything: the entry is lost, and cdb_req drops in the next cycle.

Optional Feature:
- Macro MUL_RS_PERF_CNT_EN.
- When defined, adds output perf_busy_cycles (32-bit). It increments in every cycle the FSM is in START, BUSY or WB, wraps at 2^32-1 to 0, and clears on rst.
- When undefined, the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then wait: issue_ready stays 0 for FU_LAT=7 cycles, then 1; all outputs stay 0.
- Issue dest=3, qj=qk=0, vj=6, vk=7: one fu_en pulse with fu_a=6, fu_b=7; model finish after 7 cycles with res=42; cdb_req with tag 3, data 42 holds until grant; the entry frees.
- Issue dest=2, qj=5, vk=3; broadcast tag 5 with data 0x10 two cycles later: fu_en fires after wakeup with fu_a=0x10; result 0x30 appears on tag 2.
- Issue with qk=4 in the same cycle as a broadcast of tag 4 with data 9: the entry starts as ready; fu_b=9.
- Fill both entries ready (A older): A executes first, B starts only after A's grant; issue_ready=0 while both entries are valid; withhold grant 5 cycles and check that cdb outputs stay stable.
- Assert rst mid-BUSY, then issue a new op immediately after drain: a stale fu_finish during DRAIN is ignored; the new result is correct.

Source files
------------

// File: rtl/mul_rs_ctrl.sv
// Two-entry reservation station and issue controller for the pipelined multiplier.
// Define MUL_RS_PERF_CNT_EN to add the perf_busy_cycles output.
module mul_rs_ctrl #(
  parameter int TAG_W  = 3,
  parameter int FU_LAT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic [31:0]      issue_vj,
  input  logic [31:0]      issue_vk,
  input  logic             bcast_valid,
  input  logic [TAG_W-1:0] bcast_tag,
  input  logic [31:0]      bcast_data,
  output logic             fu_en,
  output logic [31:0]      fu_a,
  output logic [31:0]      fu_b,
  input  logic [31:0]      fu_res,
  input  logic             fu_finish,
  output logic             cdb_req,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [31:0]      cdb_data,
  input  logic             cdb_grant
`ifdef MUL_RS_PERF_CNT_EN
  ,
  output logic [31:0]      perf_busy_cycles
`endif
);

  localparam int CNT_W = $clog2(FU_LAT + 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_START, S_BUSY, S_WB} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             valid_reg [2];
  logic [TAG_W-1:0] dest_reg  [2];
  logic [TAG_W-1:0] qj_reg    [2];
  logic [TAG_W-1:0] qk_reg    [2];
  logic [31:0]      vj_reg    [2];
  logic [31:0]      vk_reg    [2];
  logic             age_reg;   // index of the older entry
  logic             sel_reg;   // entry currently in the multiplier

  logic             fu_en_reg;
  logic [31:0]      fu_a_reg;
  logic [31:0]      fu_b_reg;
  logic             cdb_req_reg;
  logic [TAG_W-1:0] cdb_tag_reg;
  logic [31:0]      cdb_data_reg;

  logic [1:0] wake_j;
  logic [1:0] wake_k;
  logic [1:0] ready_vec;
  logic [1:0] free_vec;
  logic       finish_now;
  logic       issue_fire;
  logic       issue_idx;
  logic       pick;
  logic [TAG_W-1:0] in_qj;
  logic [TAG_W-1:0] in_qk;
  logic [31:0]      in_vj;
  logic [31:0]      in_vk;

  assign finish_now = (state_reg == S_BUSY) && fu_finish;

  // An entry being retired this cycle counts as free so a new op can take its slot.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      assign wake_j[gi]    = valid_reg[gi] && bcast_valid && (qj_reg[gi] != '0) && (qj_reg[gi] == bcast_tag);
      assign wake_k[gi]    = valid_reg[gi] && bcast_valid && (qk_reg[gi] != '0) && (qk_reg[gi] == bcast_tag);
      assign ready_vec[gi] = valid_reg[gi] && (qj_reg[gi] == '0) && (qk_reg[gi] == '0);
      assign free_vec[gi]  = !valid_reg[gi] || (finish_now && (sel_reg == 1'(gi)));
    end
  endgenerate

  assign issue_ready = (state_reg != S_DRAIN) && (|free_vec);
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_idx   = free_vec[0] ? 1'b0 : 1'b1;
  assign pick        = (ready_vec[0] && ready_vec[1]) ? age_reg : ready_vec[1];

  // Same-cycle broadcast bypass so a wakeup coinciding with issue is not lost.
  assign in_qj = (bcast_valid && (issue_qj != '0) && (issue_qj == bcast_tag)) ? '0 : issue_qj;
  assign in_vj = (bcast_valid && (issue_qj != '0) && (issue_qj == bcast_tag)) ? bcast_data : issue_vj;
  assign in_qk = (bcast_valid && (issue_qk != '0) && (issue_qk == bcast_tag)) ? '0 : issue_qk;
  assign in_vk = (bcast_valid && (issue_qk != '0) && (issue_qk == bcast_tag)) ? bcast_data : issue_vk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_DRAIN;
      cnt_reg      <= CNT_W'(FU_LAT);
      age_reg      <= 1'b0;
      sel_reg      <= 1'b0;
      fu_en_reg    <= 1'b0;
      fu_a_reg     <= '0;
      fu_b_reg     <= '0;
      cdb_req_reg  <= 1'b0;
      cdb_tag_reg  <= '0;
      cdb_data_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        valid_reg[i] <= 1'b0;
        dest_reg[i]  <= '0;
        qj_reg[i]    <= '0;
        qk_reg[i]    <= '0;
        vj_reg[i]    <= '0;
        vk_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wake_j[i]) begin
          vj_reg[i] <= bcast_data;
          qj_reg[i] <= '0;
        end
        if (wake_k[i]) begin
          vk_reg[i] <= bcast_data;
          qk_reg[i] <= '0;
        end
      end

      case (state_reg)
        S_DRAIN: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg <= CNT_W'(1)) state_reg <= S_IDLE;
        end
        S_IDLE: begin
          if (|ready_vec) begin
            sel_reg   <= pick;
            fu_a_reg  <= vj_reg[pick];
            fu_b_reg  <= vk_reg[pick];
            fu_en_reg <= 1'b1;
            state_reg <= S_START;
          end
        end
        S_START: begin
          fu_en_reg <= 1'b0;
          state_reg <= S_BUSY;
        end
        S_BUSY: begin
          if (fu_finish) begin
            cdb_data_reg       <= fu_res;
            cdb_tag_reg        <= dest_reg[sel_reg];
            cdb_req_reg        <= 1'b1;
            valid_reg[sel_reg] <= 1'b0;
            state_reg          <= S_WB;
          end
        end
        S_WB: begin
          if (cdb_grant) begin
            cdb_req_reg <= 1'b0;
            state_reg   <= S_IDLE;
          end
        end
        default: state_reg <= S_DRAIN;
      endcase

      // Placed after the retire so a same-cycle refill of the freed slot wins.
      if (issue_fire) begin
        valid_reg[issue_idx] <= 1'b1;
        dest_reg[issue_idx]  <= issue_dest;
        qj_reg[issue_idx]    <= in_qj;
        vj_reg[issue_idx]    <= in_vj;
        qk_reg[issue_idx]    <= in_qk;
        vk_reg[issue_idx]    <= in_vk;
        age_reg              <= ~issue_idx;
      end
    end
  end

  assign fu_en    = fu_en_reg;
  assign fu_a     = fu_a_reg;
  assign fu_b     = fu_b_reg;
  assign cdb_req  = cdb_req_reg;
  assign cdb_tag  = cdb_tag_reg;
  assign cdb_data = cdb_data_reg;

`ifdef MUL_RS_PERF_CNT_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else if ((state_reg == S_START) || (state_reg == S_BUSY) || (state_reg == S_WB)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_busy_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_mul_rs_ctrl.sv
// Scoreboard bench for mul_rs_ctrl with a behavioural multiplier model.
module tb_mul_rs_ctrl;

  localparam int TAG_W  = 3;
  localparam int FU_LAT = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_dest;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;
  logic [31:0]      issue_vj;
  logic [31:0]      issue_vk;
  logic             bcast_valid;
  logic [TAG_W-1:0] bcast_tag;
  logic [31:0]      bcast_data;
  logic             fu_en;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_res;
  logic             fu_finish;
  logic             cdb_req;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             cdb_grant;
`ifdef MUL_RS_PERF_CNT_EN
  logic [31:0]      perf_busy_cycles;
`endif

  mul_rs_ctrl #(.TAG_W(TAG_W), .FU_LAT(FU_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_dest  (issue_dest),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .bcast_valid (bcast_valid),
    .bcast_tag   (bcast_tag),
    .bcast_data  (bcast_data),
    .fu_en       (fu_en),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_res      (fu_res),
    .fu_finish   (fu_finish),
    .cdb_req     (cdb_req),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .cdb_grant   (cdb_grant)
`ifdef MUL_RS_PERF_CNT_EN
    ,
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_cyc = 0;
  int last_issue_cyc = 0;
  logic en_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: finish is high FU_LAT cycles after the fu_en cycle.
  int m_cnt = 0;
  logic [31:0] m_res;
  always @(negedge clk) begin
    fu_finish = 1'b0;
    fu_res    = 32'hBAD0_BAD0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        fu_finish = 1'b1;
        fu_res    = m_res;
      end
    end
    if (fu_en === 1'b1) begin
      m_cnt = FU_LAT;
      m_res = fu_a * fu_b;
    end
  end

  // Start monitor: every fu_en must match the next expected operand pair.
  always @(negedge clk) begin
    if (fu_en === 1'b1) begin
      if (exp_ops.size() == 0) begin
        check_val("fu_en_unexpected", 32'(fu_en), 32'd0);
      end else begin
        op_t o;
        o = exp_ops.pop_front();
        check_val("fu_a", fu_a, o.a);
        check_val("fu_b", fu_b, o.b);
      end
      en_cyc = cyc;
      if (en_prev) check_val("fu_en_pulse_width", 32'(en_prev), 32'd0);
    end
    en_prev = (fu_en === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_val("rst_issue_ready", 32'(issue_ready), 32'd0);
    check_val("rst_fu_en", 32'(fu_en), 32'd0);
    check_val("rst_fu_a", fu_a, 32'd0);
    check_val("rst_fu_b", fu_b, 32'd0);
    check_val("rst_cdb_req", 32'(cdb_req), 32'd0);
    check_val("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check_val("rst_cdb_data", cdb_data, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < FU_LAT; i++) begin
      check_val("drain_issue_ready", 32'(issue_ready), 32'd0);
      check_val("drain_cdb_req", 32'(cdb_req), 32'd0);
      tick();
    end
    check_val("post_drain_issue_ready", 32'(issue_ready), 32'd1);
  endtask

  task automatic issue_op(input logic [TAG_W-1:0] dest, input logic [TAG_W-1:0] qj,
                          input logic [TAG_W-1:0] qk, input logic [31:0] vj,
                          input logic [31:0] vk, input logic [31:0] ea, input logic [31:0] eb);
    int n;
    op_t  o;
    res_t r;
    n = 0;
    while (issue_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (issue_ready !== 1'b1) begin
      check_val("issue_ready_timeout", 32'(issue_ready), 32'd1);
      return;
    end
    o.a = ea;
    o.b = eb;
    r.tag = dest;
    r.data = ea * eb;
    exp_ops.push_back(o);
    exp_res.push_back(r);
    issue_valid = 1'b1;
    issue_dest  = dest;
    issue_qj    = qj;
    issue_qk    = qk;
    issue_vj    = vj;
    issue_vk    = vk;
    last_issue_cyc = cyc;
    $display("issue dest=%0d qj=%0d qk=%0d vj=0x%08h vk=0x%08h", dest, qj, qk, vj, vk);
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, input bit check_lat);
    int n;
    res_t r;
    n = 0;
    while (cdb_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (cdb_req !== 1'b1) begin
      check_val("cdb_req_timeout", 32'(cdb_req), 32'd1);
      return;
    end
    if (check_lat) begin
      check_val("fu_en_latency", 32'(en_cyc - last_issue_cyc), 32'd2);
      check_val("cdb_req_latency", 32'(cyc - en_cyc), 32'(FU_LAT + 1));
    end
    if (exp_res.size() == 0) begin
      check_val("cdb_req_unexpected", 32'(cdb_req), 32'd0);
      return;
    end
    r = exp_res.pop_front();
    check_val("cdb_tag", 32'(cdb_tag), 32'(r.tag));
    check_val("cdb_data", cdb_data, r.data);
    $display("result tag=%0d data=0x%08h hold=%0d", cdb_tag, cdb_data, hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val("wb_hold_req", 32'(cdb_req), 32'd1);
      check_val("wb_hold_tag", 32'(cdb_tag), 32'(r.tag));
      check_val("wb_hold_data", cdb_data, r.data);
      check_val("wb_no_fu_en", 32'(fu_en), 32'd0);
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check_val("cdb_req_drop", 32'(cdb_req), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_dest  = '0;
    issue_qj    = '0;
    issue_qk    = '0;
    issue_vj    = '0;
    issue_vk    = '0;
    bcast_valid = 1'b0;
    bcast_tag   = '0;
    bcast_data  = '0;
    cdb_grant   = 1'b0;

    do_reset();

    // Simple ready op with latency checks.
    issue_op(3'd3, 3'd0, 3'd0, 32'd6, 32'd7, 32'd6, 32'd7);
    wait_result(0, 1'b1);
    check_val("entry_freed_ready", 32'(issue_ready), 32'd1);

    // Operand A arrives by broadcast two cycles after issue.
    issue_op(3'd2, 3'd5, 3'd0, 32'hDEAD_BEEF, 32'd3, 32'h10, 32'd3);
    tick();
    check_val("no_start_before_wakeup", 32'(fu_en), 32'd0);
    bcast_valid = 1'b1;
    bcast_tag   = 3'd5;
    bcast_data  = 32'h10;
    tick();
    bcast_valid = 1'b0;
    wait_result(0, 1'b0);

    // Broadcast in the same cycle as issue.
    bcast_valid = 1'b1;
    bcast_tag   = 3'd4;
    bcast_data  = 32'd9;
    issue_op(3'd6, 3'd0, 3'd4, 32'd5, 32'h1234_5678, 32'd5, 32'd9);
    bcast_valid = 1'b0;
    wait_result(0, 1'b0);

    // Age ordering: older op sits in entry 1, younger in entry 0, both woken together.
    issue_op(3'd1, 3'd0, 3'd0, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 32'h0001_0001);
    issue_op(3'd7, 3'd6, 3'd0, 32'd0, 32'd2, 32'd5, 32'd2);
    check_val("full_issue_ready", 32'(issue_ready), 32'd0);
    wait_result(5, 1'b0);
    issue_op(3'd5, 3'd0, 3'd6, 32'd3, 32'd0, 32'd3, 32'd5);
    check_val("full_issue_ready_2", 32'(issue_ready), 32'd0);
    bcast_valid = 1'b1;
    bcast_tag   = 3'd6;
    bcast_data  = 32'd5;
    tick();
    bcast_valid = 1'b0;
    wait_result(5, 1'b0);
    wait_result(0, 1'b0);

    // Reset in the middle of a multiply; the stale finish lands during drain.
    issue_op(3'd4, 3'd0, 3'd0, 32'd100, 32'd200, 32'd100, 32'd200);
    for (int i = 0; i < 4; i++) tick();
    exp_res.delete();
    do_reset();
    issue_op(3'd3, 3'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2);
    wait_result(0, 1'b0);

    check_val("ops_drained", 32'(exp_ops.size()), 32'd0);
    check_val("results_drained", 32'(exp_res.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
